key_load_ctrl: RTL and testbench



---
 rtl/key_pkg.sv | 21 ++
 rtl/key_load_ctrl.sv | 136 +++++++++++++
 tb/tb_key_load_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key provisioning stage: default widths,
// word-count derivation and the load FSM state type.
package key_pkg;

    localparam int unsigned KEY_W_DEF  = 128;
    localparam int unsigned WORD_W_DEF = 32;

    // Words needed to assemble one key; KEY_W must be a multiple of WORD_W.
    function automatic int unsigned nwords(input int unsigned key_w, input int unsigned word_w);
        return key_w / word_w;
    endfunction

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        LOADING = 3'd1,
        VALID   = 3'd2,
        LOCKED  = 3'd3,
        ZERO    = 3'd4
    } key_load_state_t;

endpackage

// File: rtl/key_load_ctrl.sv
// Key loader: assembles WORD_W-bit words into a shadow register and publishes
// the whole key atomically on key_out. Supports lock and zeroize.
module key_load_ctrl
    import key_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned KEY_W  = KEY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              lock_req,
    input  logic              zeroize,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              locked,
    output logic              err
);

    localparam int unsigned NWORDS = nwords(KEY_W, WORD_W);
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    key_load_state_t  r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [KEY_W-1:0] r_shadow, w_shadow_nx, w_shadow_wr;
    logic [KEY_W-1:0] r_key, w_key_nx;
    logic             r_key_valid, w_key_valid_nx;
    logic             r_locked, w_locked_nx;
    logic             r_err, w_err_nx;
    logic             w_accept;

    // Ready only in a writable state with no competing lock/zeroize request.
    always_comb begin
        wr_ready = 1'b0;
        if ((r_state == EMPTY) || (r_state == LOADING) || (r_state == VALID)) begin
            wr_ready = ~zeroize & ~lock_req;
        end
    end

    assign w_accept = wr_valid & wr_ready;

    // Shadow image with the incoming word dropped into the current slot.
    always_comb begin
        w_shadow_wr = r_shadow;
        w_shadow_wr[int'(r_cnt) * WORD_W +: WORD_W] = wr_data;
    end

    // Next-state logic; zeroize overrides everything.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_shadow_nx    = r_shadow;
        w_key_nx       = r_key;
        w_key_valid_nx = r_key_valid;
        w_locked_nx    = r_locked;
        w_err_nx       = r_err;
        if (zeroize) begin
            w_state_nx     = ZERO;
            w_cnt_nx       = '0;
            w_shadow_nx    = '0;
            w_key_nx       = '0;
            w_key_valid_nx = 1'b0;
            w_locked_nx    = 1'b0;
            w_err_nx       = 1'b0;
        end else begin
            case (r_state)
                EMPTY, LOADING, VALID: begin
                    if (lock_req) begin
                        // Lock beats a same-cycle write; only a complete key can be locked.
                        if (r_state == VALID) begin
                            w_state_nx  = LOCKED;
                            w_locked_nx = 1'b1;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end else if (w_accept) begin
                        w_shadow_nx = w_shadow_wr;
                        if (r_cnt == LAST_CNT) begin
                            w_key_nx       = w_shadow_wr;
                            w_key_valid_nx = 1'b1;
                            w_cnt_nx       = '0;
                            w_state_nx     = VALID;
                        end else begin
                            // A reload from VALID withdraws the old key immediately.
                            w_key_nx       = '0;
                            w_key_valid_nx = 1'b0;
                            w_cnt_nx       = r_cnt + CNT_W'(1);
                            w_state_nx     = LOADING;
                        end
                    end
                end
                LOCKED: begin
                    if (wr_valid) begin
                        w_err_nx = 1'b1;
                    end
                end
                ZERO: begin
                    w_state_nx = EMPTY;
                end
                default: begin
                    w_state_nx = EMPTY;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_shadow    <= w_shadow_nx;
            r_key       <= w_key_nx;
            r_key_valid <= w_key_valid_nx;
            r_locked    <= w_locked_nx;
            r_err       <= w_err_nx;
        end
    end

    assign key_out   = r_key;
    assign key_valid = r_key_valid;
    assign locked    = r_locked;
    assign err       = r_err;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Scoreboard bench for key_load_ctrl: directed scenarios followed by random
// traffic, checked against a word-queue reference model.
module tb_key_load_ctrl;

    localparam int WORD_W = 32;
    localparam int KEY_W  = 128;
    localparam int NWORDS = KEY_W / WORD_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_data;
    logic              lock_req;
    logic              zeroize;
    logic [KEY_W-1:0]  key_out;
    logic              key_valid;
    logic              locked;
    logic              err;

    always #5 clk = ~clk;

    key_load_ctrl #(.WORD_W(WORD_W), .KEY_W(KEY_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .lock_req  (lock_req),
        .zeroize   (zeroize),
        .key_out   (key_out),
        .key_valid (key_valid),
        .locked    (locked),
        .err       (err)
    );

    typedef struct packed {
        logic             ready;
        logic             kv;
        logic [KEY_W-1:0] key;
        logic             lck;
        logic             er;
    } exp_t;

    exp_t             sq[$];   // expected visible outputs, one entry per driven cycle
    logic [KEY_W-1:0] kq[$];   // expected keys, in publication order
    int               n_checks = 0;
    int               n_errors = 0;

    // Reference model: accepted words of the key being loaded, plus flags.
    logic [WORD_W-1:0] m_words[$];
    logic              m_valid, m_locked, m_err, m_zero;
    logic [KEY_W-1:0]  m_key;

    task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_words.delete();
        m_valid  = 1'b0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_zero   = 1'b0;
        m_key    = '0;
    endtask

    task automatic push_exp(input logic ready);
        exp_t e;
        e.ready = ready;
        e.kv    = m_valid;
        e.key   = m_key;
        e.lck   = m_locked;
        e.er    = m_err;
        sq.push_back(e);
    endtask

    // One clock of stimulus; the model advances as of the following rising edge.
    task automatic cycle(input logic v, input logic [WORD_W-1:0] d, input logic lk, input logic z);
        logic ready;
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = v;
        wr_data  = d;
        lock_req = lk;
        zeroize  = z;
        ready = !m_locked && !m_zero && !z && !lk;
        push_exp(ready);
        if (z) begin
            model_clear();
            m_zero = 1'b1;
        end else if (m_zero) begin
            m_zero = 1'b0;
        end else if (m_locked) begin
            if (v) m_err = 1'b1;
        end else if (lk) begin
            if (m_valid) m_locked = 1'b1;
            else m_err = 1'b1;
        end else if (v) begin
            if (m_valid) begin
                m_valid = 1'b0;
                m_key   = '0;
            end
            m_words.push_back(d);
            if (m_words.size() == NWORDS) begin
                m_key = '0;
                foreach (m_words[i]) m_key = m_key | (KEY_W'(m_words[i]) << (WORD_W * i));
                m_valid = 1'b1;
                m_words.delete();
                kq.push_back(m_key);
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        lock_req = 1'b0;
        zeroize  = 1'b0;
        model_clear();
        push_exp(1'b1);
    endtask

    task automatic load4(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                         input logic [WORD_W-1:0] w2, input logic [WORD_W-1:0] w3);
        cycle(1'b1, w0, 1'b0, 1'b0);
        cycle(1'b1, w1, 1'b0, 1'b0);
        cycle(1'b1, w2, 1'b0, 1'b0);
        cycle(1'b1, w3, 1'b0, 1'b0);
    endtask

    // Status monitor: compares every driven cycle's outputs against the model.
    exp_t mon_e;
    always @(negedge clk) begin
        #2;
        if (sq.size() > 0) begin
            mon_e = sq.pop_front();
            chk("wr_ready",  KEY_W'(wr_ready),  KEY_W'(mon_e.ready));
            chk("key_valid", KEY_W'(key_valid), KEY_W'(mon_e.kv));
            chk("key_out",   key_out,           mon_e.key);
            chk("locked",    KEY_W'(locked),    KEY_W'(mon_e.lck));
            chk("err",       KEY_W'(err),       KEY_W'(mon_e.er));
        end
    end

    // Publication monitor: each rising key_valid must deliver the next expected key.
    logic prev_kv = 1'b0;
    always @(posedge clk) begin
        #1;
        if (key_valid === 1'b1 && !prev_kv) begin
            if (kq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL key_publish: got unexpected key %h expected none", key_out);
            end else begin
                chk("key_publish", key_out, kq.pop_front());
            end
        end
        prev_kv = (key_valid === 1'b1);
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        lock_req = 1'b0;
        zeroize  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);

        // Basic back-to-back load.
        do_reset();
        load4(32'h1, 32'h2, 32'h3, 32'h4);
        idle();
        #3 chk("basic_key", key_out, 128'h00000004_00000003_00000002_00000001);

        // Gapped partial load interrupted by reset, then a clean reload.
        do_reset();
        cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        idle();
        cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        idle();
        cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        idle();
        cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        idle();
        #3 chk("gapped_key", key_out, {4{32'hA5A5_A5A5}});

        // Reload from VALID withdraws the old key on the first new word.
        load4(32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0);
        idle();

        // Lock, then a refused write.
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle();

        // lock_req with no key, then zeroize and recovery.
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle();
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle();
        idle();

        // zeroize + lock_req + write together in VALID.
        load4(32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004);
        cycle(1'b1, 32'h5555_5555, 1'b1, 1'b1);
        idle();
        idle();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 6, $urandom,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            end
        end
        idle();
        idle();
        @(negedge clk);
        #4;
        chk("status_queue_drained", KEY_W'(sq.size()), '0);
        chk("key_queue_drained",    KEY_W'(kq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
